stream_decipher_rx: RTL



---
 rtl/stream_decipher_rx_if.sv | 30 +++
 rtl/stream_decipher_rx.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/stream_decipher_rx_if.sv
// Ciphertext-in / plaintext-out valid/ready channels of stream_decipher_rx.
// Signal names are taken from the decipher's point of view.
interface stream_decipher_rx_if #(
  parameter int DATA_W = 8
);
  logic              i_cipher_valid;
  logic              o_cipher_ready;
  logic [DATA_W-1:0] i_cipher_data;
  logic              o_plain_valid;
  logic              i_plain_ready;
  logic [DATA_W-1:0] o_plain_data;

  modport master (
    output i_cipher_valid,
    input  o_cipher_ready,
    output i_cipher_data,
    input  o_plain_valid,
    output i_plain_ready,
    input  o_plain_data
  );

  modport slave (
    input  i_cipher_valid,
    output o_cipher_ready,
    input  i_cipher_data,
    output o_plain_valid,
    input  i_plain_ready,
    output o_plain_data
  );
endinterface

// File: rtl/stream_decipher_rx.sv
// Receive-side LFSR keystream decipher with valid/ready channels.
// STREAM_DECIPHER_MON_EN adds the o_lfsr / o_word_cnt debug outputs.
module stream_decipher_rx #(
  parameter int DATA_W = 8,
  parameter int WARMUP = 0
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  input  logic         i_seed_load,
  input  logic [127:0] i_seed,
  stream_decipher_rx_if.slave bus,
  output logic         o_seed_zero
`ifdef STREAM_DECIPHER_MON_EN
  ,
  output logic [127:0] o_lfsr,
  output logic [31:0]  o_word_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WARM,
    S_GEN,
    S_RDY
  } state_e;

  localparam int CW = 10;
  localparam state_e LOAD_ST =
    (WARMUP == 0) ? S_GEN : S_WARM;
  localparam logic [CW-1:0] WARM_LAST =
    CW'((WARMUP > 0) ? WARMUP - 1 : 0);
  localparam logic [CW-1:0] GEN_LAST =
    CW'(DATA_W - 1);

  state_e            state_q, state_d;
  logic [127:0]      lfsr_q, lfsr_d;
  logic [DATA_W-1:0] ks_word_q, ks_word_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              plain_valid_q, plain_valid_d;
  logic [DATA_W-1:0] plain_data_q, plain_data_d;
  logic              seed_zero_q, seed_zero_d;

  logic [127:0]      lfsr_nxt;
  logic              accept;

  assign lfsr_nxt = {
    lfsr_q[127] ^ lfsr_q[6] ^ lfsr_q[1] ^ lfsr_q[0],
    lfsr_q[127:1]
  };

  // A load in the same cycle must never swallow a word.
  assign bus.o_cipher_ready =
    (state_q == S_RDY) &&
    (!plain_valid_q || bus.i_plain_ready) &&
    !i_seed_load;

  assign accept = bus.i_cipher_valid && bus.o_cipher_ready;

  always_comb begin
    state_d       = state_q;
    lfsr_d        = lfsr_q;
    ks_word_d     = ks_word_q;
    cnt_d         = cnt_q;
    plain_valid_d = plain_valid_q;
    plain_data_d  = plain_data_q;
    seed_zero_d   = seed_zero_q;

    if (plain_valid_q && bus.i_plain_ready)
      plain_valid_d = 1'b0;

    if (i_seed_load) begin
      lfsr_d        = i_seed;
      ks_word_d     = '0;
      cnt_d         = '0;
      plain_valid_d = 1'b0;
      seed_zero_d   = (i_seed == '0);
      state_d       = LOAD_ST;
    end else begin
      case (state_q)
        S_IDLE: ;
        S_WARM: begin
          lfsr_d = lfsr_nxt;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == WARM_LAST) begin
            cnt_d   = '0;
            state_d = S_GEN;
          end
        end
        S_GEN: begin
          lfsr_d    = lfsr_nxt;
          // Shift in at the MSB so the first bit lands on bit 0.
          ks_word_d = (ks_word_q >> 1) |
            (DATA_W'(lfsr_q[0]) << (DATA_W - 1));
          cnt_d     = cnt_q + 1'b1;
          if (cnt_q == GEN_LAST) begin
            cnt_d   = '0;
            state_d = S_RDY;
          end
        end
        S_RDY: begin
          if (accept) begin
            plain_valid_d = 1'b1;
            plain_data_d  =
              bus.i_cipher_data ^ ks_word_q;
            cnt_d         = '0;
            state_d       = S_GEN;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q       <= S_IDLE;
      lfsr_q        <= '0;
      ks_word_q     <= '0;
      cnt_q         <= '0;
      plain_valid_q <= 1'b0;
      plain_data_q  <= '0;
      seed_zero_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      lfsr_q        <= lfsr_d;
      ks_word_q     <= ks_word_d;
      cnt_q         <= cnt_d;
      plain_valid_q <= plain_valid_d;
      plain_data_q  <= plain_data_d;
      seed_zero_q   <= seed_zero_d;
    end
  end

  assign bus.o_plain_valid = plain_valid_q;
  assign bus.o_plain_data  = plain_data_q;
  assign o_seed_zero       = seed_zero_q;

`ifdef STREAM_DECIPHER_MON_EN
  logic [31:0] word_cnt_q, word_cnt_d;

  always_comb begin
    word_cnt_d = word_cnt_q;
    if (i_seed_load)
      word_cnt_d = '0;
    else if (accept)
      word_cnt_d = word_cnt_q + 32'd1;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)
      word_cnt_q <= '0;
    else
      word_cnt_q <= word_cnt_d;
  end

  assign o_lfsr     = lfsr_q;
  assign o_word_cnt = word_cnt_q;
`endif

endmodule
